// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: state encoding and output buffer depth shared by the stream reader
package fifo_reader_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, FLUSH = 2'd3} state_t;
  localparam int BUF_DEPTH = 2;
endpackage

// File: rtl/fifo_reader_if.sv
// fifo_reader_if: fifo_sync read port plus valid/ready output stream of the reader
interface fifo_reader_if #(parameter int W = 16);
  logic fifo_empty, fifo_underflow, fifo_ren;
  logic [W-1:0] fifo_rdata;
  logic m_valid, m_ready;
  logic [W-1:0] m_data;
  modport master (input fifo_empty, fifo_underflow, fifo_rdata, m_ready, output fifo_ren, m_valid, m_data);
  modport slave (output fifo_empty, fifo_underflow, fifo_rdata, m_ready, input fifo_ren, m_valid, m_data);
endinterface

// File: rtl/fifo_reader_skidbuf.sv
// fifo_reader_skidbuf: 2-entry output buffer with a registered head word
module fifo_reader_skidbuf import fifo_reader_pkg::*; #(parameter int W = 16) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);
  logic [1:0] cnt_q, cnt_d;
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  always_comb begin
    cnt_d = clear ? 2'd0 : cnt_q + 2'(push) - 2'(pop);
    head_d = pop ? (cnt_q == 2'(BUF_DEPTH) ? tail_q : (push ? wdata : head_q))
                 : (cnt_q == 2'd0 && push ? wdata : head_q);
    tail_d = push && (pop ? cnt_q == 2'(BUF_DEPTH) : cnt_q == 2'd1) ? wdata : tail_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
  assign occ = cnt_q;
  assign head = head_q;
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a fifo_sync read port into a full-throughput valid/ready stream
module fifo_stream_reader import fifo_reader_pkg::*; #(
  parameter int pDATA_WIDTH  = 16,
  parameter bit pFALLTHROUGH = 1'b0,
  parameter int pCOUNT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    flush,
  input  logic                    clear_stats,
  fifo_reader_if.master           bus,
  output logic                    busy,
  output logic [pCOUNT_WIDTH-1:0] words_read,
  output logic                    underflow_seen
);
  state_t state_q, state_d;
  logic inflight_q, inflight_d, uf_q, uf_d, pop, push;
  logic [pCOUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0] occ;
  logic [pDATA_WIDTH-1:0] head;
  fifo_reader_skidbuf #(.W(pDATA_WIDTH)) u_buf (
    .clk, .rst(reset), .clear(flush), .push, .pop, .wdata(bus.fifo_rdata), .occ, .head
  );
  always_comb begin
    pop = occ != 2'd0 && bus.m_ready;
    // standard mode: a word popped now frees the slot a read issued now lands in next cycle
    bus.fifo_ren = state_q == RUN && enable && !flush && !bus.fifo_empty &&
                   int'(occ) + int'(inflight_q) < BUF_DEPTH + int'(!pFALLTHROUGH && pop);
    push = pFALLTHROUGH ? bus.fifo_ren : inflight_q;
    inflight_d = !pFALLTHROUGH && bus.fifo_ren;
    state_d = flush ? FLUSH : enable ? RUN :
              (state_q == RUN || (state_q == DRAIN && (occ != 2'd0 || inflight_q))) ? DRAIN : IDLE;
    cnt_d = clear_stats ? '0 : (pop && !(&cnt_q)) ? cnt_q + pCOUNT_WIDTH'(1) : cnt_q;
    uf_d = !clear_stats && (uf_q || bus.fifo_underflow || (bus.fifo_ren && bus.fifo_empty));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      inflight_q <= 1'b0;
      cnt_q <= '0;
      uf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      inflight_q <= inflight_d;
      cnt_q <= cnt_d;
      uf_q <= uf_d;
    end
  end
  assign bus.m_valid = occ != 2'd0;
  assign bus.m_data = head;
  assign busy = state_q != IDLE || occ != 2'd0 || inflight_q;
  assign words_read = cnt_q;
  assign underflow_seen = uf_q;
endmodule
